// File: rtl/demux4x14_tdm.sv
// Receive-side TDM demultiplexer: rebuilds four parallel channel words from one
// interleaved sample stream, aligned on SYNC, with a flywheel for missing SYNCs.
module demux4x14_tdm #(
  parameter int W       = 14,
  parameter int MAXMISS = 3
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] din_i,
  input  logic         vin_i,
  input  logic         sync_i,
  input  logic         clrerr_i,
  output logic [W-1:0] q0_o,
  output logic [W-1:0] q1_o,
  output logic [W-1:0] q2_o,
  output logic [W-1:0] q3_o,
  output logic         vout_o,
  output logic [1:0]   s_o,
  output logic         lock_o,
  output logic         err_o
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [1:0]          slot_q, slot_d;
  logic [2:0]          miss_q, miss_d;
  logic [2:0][W-1:0]   sh_q, sh_d;
  logic [3:0][W-1:0]   q_q, q_d;
  logic                vout_q, vout_d;
  logic                err_q, err_d;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    miss_d  = miss_q;
    sh_d    = sh_q;
    q_d     = q_q;
    vout_d  = 1'b0;
    // A misalignment set on the same edge overrides the clear below.
    err_d   = err_q & ~clrerr_i;

    if (vin_i) begin
      if (state_q == HUNT) begin
        if (sync_i) begin
          sh_d[0] = din_i;
          slot_d  = 2'd1;
          state_d = LOCKED;
          miss_d  = 3'd0;
        end
      end else if (sync_i) begin
        if (slot_q != 2'd0) begin
          err_d = 1'b1;
        end
        sh_d[0] = din_i;
        slot_d  = 2'd1;
        miss_d  = 3'd0;
      end else begin
        case (slot_q)
          2'd0: begin
            if (miss_q == 3'(MAXMISS - 1)) begin
              state_d = HUNT;
              slot_d  = 2'd0;
              miss_d  = 3'd0;
            end else begin
              sh_d[0] = din_i;
              slot_d  = 2'd1;
              miss_d  = miss_q + 3'd1;
            end
          end
          2'd1: begin
            sh_d[1] = din_i;
            slot_d  = 2'd2;
          end
          2'd2: begin
            sh_d[2] = din_i;
            slot_d  = 2'd3;
          end
          default: begin
            q_d    = {din_i, sh_q[2], sh_q[1], sh_q[0]};
            vout_d = 1'b1;
            slot_d = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      miss_q  <= 3'd0;
      sh_q    <= '0;
      q_q     <= '0;
      vout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      miss_q  <= miss_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      vout_q  <= vout_d;
      err_q   <= err_d;
    end
  end

  assign q0_o   = q_q[0];
  assign q1_o   = q_q[1];
  assign q2_o   = q_q[2];
  assign q3_o   = q_q[3];
  assign vout_o = vout_q;
  assign s_o    = slot_q;
  assign lock_o = (state_q == LOCKED);
  assign err_o  = err_q;

endmodule

// File: tb/tb_demux4x14_tdm.sv
// Bench for demux4x14_tdm: directed scenarios plus a random run, every cycle
// compared against a queue-based frame model.
module tb_demux4x14_tdm;
  localparam int W       = 14;
  localparam int MAXMISS = 3;
  localparam int VW      = 4*W + 5;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic [W-1:0] din_i;
  logic         vin_i, sync_i, clrerr_i;
  logic [W-1:0] q0_o, q1_o, q2_o, q3_o;
  logic         vout_o, lock_o, err_o;
  logic [1:0]   s_o;

  always #5 clk_i = ~clk_i;

  demux4x14_tdm #(.W(W), .MAXMISS(MAXMISS)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .din_i(din_i), .vin_i(vin_i),
    .sync_i(sync_i), .clrerr_i(clrerr_i),
    .q0_o(q0_o), .q1_o(q1_o), .q2_o(q2_o), .q3_o(q3_o),
    .vout_o(vout_o), .s_o(s_o), .lock_o(lock_o), .err_o(err_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: samples of the frame in progress are held in a queue.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_out[4];
  bit           m_locked, m_vout, m_err;
  int           m_miss;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {q3_o, q2_o, q1_o, q0_o, vout_o, s_o, lock_o, err_o};

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    m_locked = 0; m_vout = 0; m_err = 0; m_miss = 0;
  endfunction

  function automatic void model_step(bit v, bit s, logic [W-1:0] d, bit c);
    bit set_err = 0;
    m_vout = 0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin mq = {d}; m_locked = 1; m_miss = 0; end
      end else if (s) begin
        if (mq.size() != 0) set_err = 1;
        mq = {d};
        m_miss = 0;
      end else if (mq.size() == 0) begin
        m_miss++;
        if (m_miss >= MAXMISS) begin m_locked = 0; m_miss = 0; end
        else mq.push_back(d);
      end else begin
        mq.push_back(d);
        if (mq.size() == 4) begin
          for (int i = 0; i < 4; i++) m_out[i] = mq[i];
          m_vout = 1;
          mq.delete();
        end
      end
    end
    if (set_err) m_err = 1;
    else if (c)  m_err = 0;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [1:0] s = m_locked ? 2'(mq.size()) : 2'd0;
    return {m_out[3], m_out[2], m_out[1], m_out[0], m_vout, s, m_locked, m_err};
  endfunction

  task automatic drive(bit v, bit s, logic [W-1:0] d, bit c = 0);
    vin_i = v; sync_i = s; din_i = d; clrerr_i = c;
    @(posedge clk_i); #1;
    model_step(v, s, d, c);
  endtask

  task automatic do_reset();
    vin_i = 0; sync_i = 0; din_i = '0; clrerr_i = 0;
    rst_n_i = 0;
    #3;
    model_reset();
    @(posedge clk_i); #1;
    rst_n_i = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dut_vec !== '0) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", dut_vec);
    end
    drive(0, 0, '0);
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_basic_frame();
    logic [W-1:0] vals[4] = '{14'h0001, 14'h0002, 14'h0003, 14'h3FFF};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, vals[i]);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL basic_slot%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if ({q3_o, q2_o, q1_o, q0_o, vout_o, lock_o, err_o} !== {14'h3FFF, 14'h0003, 14'h0002, 14'h0001, 3'b110}) begin
      n_fail++; $display("FAIL basic_q: got %h %h %h %h v%b l%b e%b want 3fff 0003 0002 0001 v1 l1 e0",
                         q3_o, q2_o, q1_o, q0_o, vout_o, lock_o, err_o);
    end
    drive(0, 0, '0);
    n_cmp++;
    if (vout_o !== 1'b0 || q3_o !== 14'h3FFF) begin
      n_fail++; $display("FAIL basic_vout_width: got vout=%b q3=%h want vout=0 q3=3fff", vout_o, q3_o);
    end
  endtask

  task automatic test_hunt();
    logic [W-1:0] vals[4] = '{14'h000A, 14'h000B, 14'h000C, 14'h000D};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 14'(16'h1230 + i));
      n_cmp++;
      if (s_o !== 2'd0 || lock_o !== 1'b0 || dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL hunt_discard%0d: got s=%0d lock=%b want s=0 lock=0", i, s_o, lock_o);
      end
    end
    for (int i = 0; i < 4; i++) drive(1, i == 0, vals[i]);
    n_cmp++;
    if ({q3_o, q2_o, q1_o, q0_o, vout_o} !== {14'h000D, 14'h000C, 14'h000B, 14'h000A, 1'b1} || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL hunt_frame: got %h %h %h %h v%b want 000d 000c 000b 000a v1", q3_o, q2_o, q1_o, q0_o, vout_o);
    end
  endtask

  task automatic test_misalign();
    int vcnt = 0;
    drive(1, 1, 14'h0050);
    drive(1, 0, 14'h0051);
    drive(1, 1, 14'h0100);
    if (vout_o) vcnt++;
    n_cmp++;
    if (err_o !== 1'b1 || s_o !== 2'd1 || lock_o !== 1'b1) begin
      n_fail++; $display("FAIL misalign_err: got err=%b s=%0d lock=%b want err=1 s=1 lock=1", err_o, s_o, lock_o);
    end
    for (int i = 1; i < 4; i++) begin
      drive(1, 0, 14'(16'h0100 + i));
      if (vout_o) vcnt++;
    end
    n_cmp++;
    if (vcnt != 1 || {q3_o, q2_o, q1_o, q0_o} !== {14'h0103, 14'h0102, 14'h0101, 14'h0100}) begin
      n_fail++; $display("FAIL misalign_frame: got vouts=%0d q=%h %h %h %h want 1 0103 0102 0101 0100", vcnt, q3_o, q2_o, q1_o, q0_o);
    end
    drive(0, 0, '0, 1);
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL misalign_clr: got err=%b want 0", err_o);
    end
    drive(1, 1, 14'h0200);
    drive(1, 1, 14'h0201, 1);
    n_cmp++;
    if (err_o !== 1'b1 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL misalign_set_wins: got err=%b want 1", err_o);
    end
    drive(0, 0, '0, 1);
    for (int i = 2; i < 5; i++) drive(1, 0, 14'(16'h0200 + i));
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL misalign_recover: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_flywheel();
    int vcnt = 0;
    for (int i = 0; i < 4; i++) drive(1, i == 0, 14'(16'h0300 + i));
    for (int f = 1; f <= 2; f++)
      for (int i = 0; i < 4; i++) begin
        drive(1, 0, 14'(16'h0300 + 16 * f + i));
        if (vout_o) vcnt++;
      end
    n_cmp++;
    if (vcnt != 2 || lock_o !== 1'b1 || q0_o !== 14'h0320) begin
      n_fail++; $display("FAIL flywheel_frames: got vouts=%0d lock=%b q0=%h want 2 1 0320", vcnt, lock_o, q0_o);
    end
    drive(1, 0, 14'h0330);
    n_cmp++;
    if (lock_o !== 1'b0 || s_o !== 2'd0 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL flywheel_drop: got lock=%b s=%0d want lock=0 s=0", lock_o, s_o);
    end
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 14'(16'h0340 + i));
      if (vout_o) vcnt++;
    end
    n_cmp++;
    if (vcnt != 0 || lock_o !== 1'b0) begin
      n_fail++; $display("FAIL flywheel_hunt: got vouts=%0d lock=%b want 0 0", vcnt, lock_o);
    end
    for (int i = 0; i < 4; i++) drive(1, i == 0, 14'(16'h0350 + i));
    n_cmp++;
    if (vout_o !== 1'b1 || q3_o !== 14'h0353 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL flywheel_relock: got vout=%b q3=%h want 1 0353", vout_o, q3_o);
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] vals[4];
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 4; i++) vals[i] = 14'($urandom);
      for (int i = 0; i < 4; i++) begin
        int gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          logic [1:0] s_before = s_o;
          drive(0, $urandom_range(0, 1), 14'($urandom));
          n_cmp++;
          if (s_o !== s_before || vout_o !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL gaps_hold: got %h want %h", dut_vec, exp_vec());
          end
        end
        drive(1, i == 0, vals[i]);
      end
      n_cmp++;
      if ({q3_o, q2_o, q1_o, q0_o, vout_o} !== {vals[3], vals[2], vals[1], vals[0], 1'b1}) begin
        n_fail++; $display("FAIL gaps_frame%0d: got %h %h %h %h v%b want %h %h %h %h v1",
                           f, q3_o, q2_o, q1_o, q0_o, vout_o, vals[3], vals[2], vals[1], vals[0]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    drive(1, 1, 14'h1111);
    drive(1, 0, 14'h2222);
    rst_n_i = 0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec !== '0) begin
      n_fail++; $display("FAIL midreset_clear: got %h want 0", dut_vec);
    end
    vin_i = 0;
    @(posedge clk_i); #1;
    rst_n_i = 1;
    drive(1, 0, 14'h3333);
    for (int i = 0; i < 4; i++) drive(1, i == 0, 14'(16'h0400 + i));
    n_cmp++;
    if ({q3_o, q2_o, q1_o, q0_o} !== {14'h0403, 14'h0402, 14'h0401, 14'h0400} || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL midreset_frame: got %h %h %h %h want 0403 0402 0401 0400", q3_o, q2_o, q1_o, q0_o);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      bit v = ($urandom_range(0, 3) != 0);
      bit at0 = !m_locked || mq.size() == 0;
      bit s = at0 ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 19) == 0);
      drive(v, s, 14'($urandom), $urandom_range(0, 9) == 0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h want %h", n, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n_i = 0; vin_i = 0; sync_i = 0; din_i = '0; clrerr_i = 0;
    model_reset();
    test_reset();
    test_basic_frame();
    test_hunt();
    test_misalign();
    test_flywheel();
    test_gaps();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
